// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus master, the memory model and benches:
// default bus widths, FSM state encoding and small helper functions.
package mem_bus_master_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 26;
    localparam int LAT_CNT_WIDTH      = 4;
    localparam int COUNT_WIDTH        = 32;

    // IDLE is also the bus turnaround cycle between any two operations.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10
    } bus_state_e;

    // The data bus may only be driven during a pure write cycle.
    function automatic logic bus_drive_enable(input logic mem_write, input logic mem_read);
        return mem_write & ~mem_read;
    endfunction

    // Starting value of the read latency down-counter (latency 1 starts at 0).
    function automatic logic [LAT_CNT_WIDTH-1:0] lat_reload(input int read_latency);
        return LAT_CNT_WIDTH'(read_latency - 32'sd1);
    endfunction

    // Wrapping event counter increment; wraps to zero without any flag.
    function automatic logic [COUNT_WIDTH-1:0] count_inc(input logic [COUNT_WIDTH-1:0] value);
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response handshake plus memory control signals of the bus master.
// The shared data bus stays a plain inout net on the master itself.
interface mem_bus_master_if
    import mem_bus_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;

    // Bus master view.
    modport master (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output mem_addr,
        output mem_read,
        output mem_write
    );

    // Environment view: request source, response sink and memory.
    modport slave (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  mem_addr,
        input  mem_read,
        input  mem_write
    );

endinterface

// File: rtl/mem_bus_drv.sv
// Tristate driver for the shared memory data bus. Drives the registered write
// data only while enabled, otherwise releases every bit to z.
module mem_bus_drv
    import mem_bus_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  drive_en,
    input  logic [DATA_WIDTH-1:0] drive_data,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    // Drive the bus during a write cycle, float it otherwise.
    assign mem_data = drive_en ? drive_data : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/mem_bus_master.sv
// Single-port memory bus master: accepts one read or write request at a time,
// generates the memory bus cycle, returns read data on a one-cycle strobe and
// keeps one idle turnaround cycle between consecutive bus operations.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_bus_master_if.master       bus,
    inout  wire  [DATA_WIDTH-1:0]  mem_data,
    output logic [COUNT_WIDTH-1:0] wr_count,
    output logic [COUNT_WIDTH-1:0] rd_count
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_START = lat_reload(READ_LATENCY);

    bus_state_e               state_r;
    logic [LAT_CNT_WIDTH-1:0] lat_cnt_r;
    logic                     req_ready_r;
    logic                     rsp_valid_r;
    logic [DATA_WIDTH-1:0]    rsp_rdata_r;
    logic [ADDR_WIDTH-1:0]    mem_addr_r;
    logic                     mem_read_r;
    logic                     mem_write_r;
    logic [DATA_WIDTH-1:0]    wdata_r;
    logic [COUNT_WIDTH-1:0]   wr_count_r;
    logic [COUNT_WIDTH-1:0]   rd_count_r;
    logic                     accept_s;
    logic                     drive_en_s;

    // A request is taken only when the registered ready is high, i.e. in IDLE.
    assign accept_s   = bus.req_valid & req_ready_r;
    assign drive_en_s = bus_drive_enable(mem_write_r, mem_read_r);

    // Bus FSM, read latency counter, response capture and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            lat_cnt_r   <= {LAT_CNT_WIDTH{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            wr_count_r  <= {COUNT_WIDTH{1'b0}};
            rd_count_r  <= {COUNT_WIDTH{1'b0}};
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mem_addr_r  <= bus.req_addr;
                        wdata_r     <= bus.req_wdata;
                        req_ready_r <= 1'b0;
                        if (bus.req_write) begin
                            state_r     <= WRITE;
                            mem_write_r <= 1'b1;
                            mem_read_r  <= 1'b0;
                        end else begin
                            state_r     <= READ;
                            mem_read_r  <= 1'b1;
                            mem_write_r <= 1'b0;
                            lat_cnt_r   <= LAT_START;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                WRITE: begin
                    // Single write cycle; the memory latches at this edge.
                    mem_write_r <= 1'b0;
                    wr_count_r  <= count_inc(wr_count_r);
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                READ: begin
                    if (lat_cnt_r == {LAT_CNT_WIDTH{1'b0}}) begin
                        // Capture the bus as-is, including any x/z bits.
                        rsp_rdata_r <= mem_data;
                        rsp_valid_r <= 1'b1;
                        rd_count_r  <= count_inc(rd_count_r);
                        mem_read_r  <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet bus.
                    state_r     <= IDLE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    req_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_read  = mem_read_r;
    assign bus.mem_write = mem_write_r;
    assign wr_count      = wr_count_r;
    assign rd_count      = rd_count_r;

    mem_bus_drv #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_drv (
        .drive_en   (drive_en_s),
        .drive_data (wdata_r),
        .mem_data   (mem_data)
    );

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (read latency 1 and 3), each with a
// small word memory on a pulled-up data bus so a released bus reads all ones.
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

    localparam int NI       = 2;
    localparam int MEM_WORDS = 8192;
    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    logic mon_en = 1'b0;

    logic        req_valid_a [NI];
    logic        req_write_a [NI];
    logic [25:0] req_addr_a  [NI];
    logic [31:0] req_wdata_a [NI];
    logic        req_ready_a [NI];
    logic        rsp_valid_a [NI];
    logic [31:0] rsp_rdata_a [NI];
    logic [25:0] mem_addr_a  [NI];
    logic        mem_read_a  [NI];
    logic        mem_write_a [NI];
    logic [31:0] mem_data_a  [NI];
    logic [31:0] wr_count_a  [NI];
    logic [31:0] rd_count_a  [NI];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: logical memory contents and expected counters.
    logic [31:0] ref_mem [int unsigned];
    int unsigned exp_wr [NI];
    int unsigned exp_rd [NI];
    logic [31:0] last_rd [NI];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Content of a word that was never written: preload image or zero.
    function automatic logic [31:0] image_word(input logic [25:0] a);
        if (a >= 26'h1000 && a <= 26'h100F) return 32'h0041_4020 + 32'(a - 26'h1000);
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_read(input int sel, input logic [25:0] a);
        int unsigned key = (int'(sel) << 26) | int'(a);
        if (ref_mem.exists(key)) return ref_mem[key];
        return image_word(a);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        mem_bus_master_if bus ();
        wire  [31:0] mem_data;
        logic [31:0] store   [MEM_WORDS];
        logic        written [MEM_WORDS];
        logic [31:0] mem_q;

        assign bus.req_valid = req_valid_a[g];
        assign bus.req_write = req_write_a[g];
        assign bus.req_addr  = req_addr_a[g];
        assign bus.req_wdata = req_wdata_a[g];
        assign req_ready_a[g] = bus.req_ready;
        assign rsp_valid_a[g] = bus.rsp_valid;
        assign rsp_rdata_a[g] = bus.rsp_rdata;
        assign mem_addr_a[g]  = bus.mem_addr;
        assign mem_read_a[g]  = bus.mem_read;
        assign mem_write_a[g] = bus.mem_write;
        assign mem_data_a[g]  = mem_data;

        mem_bus_master #(.READ_LATENCY(LAT)) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .mem_data (mem_data),
            .wr_count (wr_count_a[g]),
            .rd_count (rd_count_a[g])
        );

        for (genvar b = 0; b < 32; b++) begin : g_pu
            pullup pu (mem_data[b]);
        end

        // Memory read path: drives the bus while MEM_READ is high.
        always_comb begin
            mem_q = image_word(bus.mem_addr);
            if (written[bus.mem_addr[12:0]]) mem_q = store[bus.mem_addr[12:0]];
        end
        assign mem_data = bus.mem_read ? mem_q : 32'bz;

        // Memory write path: latches the bus at the end of a write cycle.
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < MEM_WORDS; i++) written[i] <= 1'b0;
            end else if (bus.mem_write && !bus.mem_read) begin
                store[bus.mem_addr[12:0]]   <= mem_data;
                written[bus.mem_addr[12:0]] <= 1'b1;
            end
        end

        // Protocol monitor on every cycle.
        always @(negedge clk) begin
            if (mon_en) begin
                check("proto_rw_excl", 64'(bus.mem_read & bus.mem_write), 64'd0);
                if (!bus.mem_write && !bus.mem_read)
                    check("proto_bus_released", 64'(mem_data), 64'(RELEASED));
                check("proto_accept_busy",
                      64'(bus.req_valid & bus.req_ready & (bus.mem_read | bus.mem_write)), 64'd0);
            end
        end
    end

    task automatic check_reset(input int sel);
        check("rst_req_ready", 64'(req_ready_a[sel]), 64'd0);
        check("rst_mem_read",  64'(mem_read_a[sel]),  64'd0);
        check("rst_mem_write", 64'(mem_write_a[sel]), 64'd0);
        check("rst_mem_addr",  64'(mem_addr_a[sel]),  64'd0);
        check("rst_mem_data",  64'(mem_data_a[sel]),  64'(RELEASED));
        check("rst_rsp_valid", 64'(rsp_valid_a[sel]), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata_a[sel]), 64'd0);
        check("rst_wr_count",  64'(wr_count_a[sel]),  64'd0);
        check("rst_rd_count",  64'(rd_count_a[sel]),  64'd0);
    endtask

    function automatic void clear_expect();
        for (int s = 0; s < NI; s++) begin
            exp_wr[s]  = 0;
            exp_rd[s]  = 0;
            last_rd[s] = 32'd0;
        end
    endfunction

    // Presents a request (called just after a falling edge), waits for the
    // accept and checks every cycle of the operation. Returns at the falling
    // edge of the cycle where the master is ready again.
    task automatic do_req(input int sel, input bit wr, input logic [25:0] addr, input logic [31:0] data);
        int lat = (sel == 0) ? 1 : 3;
        int waited = 0;
        logic [31:0] exp_data;
        req_valid_a[sel] = 1'b1;
        req_write_a[sel] = wr;
        req_addr_a[sel]  = addr;
        req_wdata_a[sel] = data;
        while (!req_ready_a[sel] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            check("accept_timeout", 64'd1, 64'd0);
            req_valid_a[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_a[sel] = 1'b0;
        req_addr_a[sel]  = 26'($urandom);
        req_wdata_a[sel] = $urandom;
        if (wr) begin
            check("wr_mem_write", 64'(mem_write_a[sel]), 64'd1);
            check("wr_mem_addr",  64'(mem_addr_a[sel]),  64'(addr));
            check("wr_mem_data",  64'(mem_data_a[sel]),  64'(data));
            check("wr_req_ready", 64'(req_ready_a[sel]), 64'd0);
            check("wr_rsp_valid", 64'(rsp_valid_a[sel]), 64'd0);
            check("wr_rsp_hold",  64'(rsp_rdata_a[sel]), 64'(last_rd[sel]));
            ref_mem[(int'(sel) << 26) | int'(addr)] = data;
            exp_wr[sel]++;
            @(negedge clk);
            check("wr_done_mem_write", 64'(mem_write_a[sel]), 64'd0);
            check("wr_done_ready",     64'(req_ready_a[sel]), 64'd1);
            check("wr_count",          64'(wr_count_a[sel]),  64'(exp_wr[sel]));
        end else begin
            exp_data = ref_read(sel, addr);
            for (int c = 0; c < lat; c++) begin
                if (c > 0) @(negedge clk);
                check("rd_mem_read",  64'(mem_read_a[sel]),  64'd1);
                check("rd_mem_write", 64'(mem_write_a[sel]), 64'd0);
                check("rd_mem_addr",  64'(mem_addr_a[sel]),  64'(addr));
                check("rd_req_ready", 64'(req_ready_a[sel]), 64'd0);
                check("rd_rsp_early", 64'(rsp_valid_a[sel]), 64'd0);
            end
            @(negedge clk);
            exp_rd[sel]++;
            last_rd[sel] = exp_data;
            check("rd_rsp_valid", 64'(rsp_valid_a[sel]), 64'd1);
            check("rd_rsp_rdata", 64'(rsp_rdata_a[sel]), 64'(exp_data));
            check("rd_count",     64'(rd_count_a[sel]),  64'(exp_rd[sel]));
            check("rd_done_ready", 64'(req_ready_a[sel]), 64'd1);
            check("rd_done_mem_read", 64'(mem_read_a[sel]), 64'd0);
        end
    endtask

    task automatic random_ops(input int sel, input int n);
        logic [25:0] a;
        for (int i = 0; i < n; i++) begin
            a = 26'($urandom_range(0, 15)) + (($urandom_range(0, 1) == 1) ? 26'h1000 : 26'h40);
            repeat ($urandom_range(0, 2)) begin
                req_addr_a[sel] = 26'($urandom);
                @(negedge clk);
            end
            do_req(sel, ($urandom_range(0, 1) == 1), a, $urandom);
        end
    endtask

    // Bounded run time.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_clr = 1'b1;
        clear_expect();
        for (int s = 0; s < NI; s++) begin
            req_valid_a[s] = 1'b0;
            req_write_a[s] = 1'b0;
            req_addr_a[s]  = 26'd0;
            req_wdata_a[s] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        mem_clr = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Latency 1: back-to-back writes, read-back, preload image, random.
        for (int i = 0; i < 10; i++) do_req(0, 1'b1, 26'(i), 32'(i));
        for (int i = 0; i < 10; i++) do_req(0, 1'b0, 26'(i), 32'd0);
        for (int i = 0; i < 16; i++) do_req(0, 1'b0, 26'h1000 + 26'(i), 32'd0);
        check("final_wr_count_l1", 64'(wr_count_a[0]), 64'd10);
        random_ops(0, 40);

        // Latency 3: same write/read-back, then random traffic.
        for (int i = 0; i < 10; i++) do_req(1, 1'b1, 26'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 10; i++) do_req(1, 1'b0, 26'(i), 32'd0);
        check("final_rd_count_l3", 64'(rd_count_a[1]), 64'd10);
        random_ops(1, 30);

        // Reset in the middle of a latency-3 read.
        req_valid_a[1] = 1'b1;
        req_write_a[1] = 1'b0;
        req_addr_a[1]  = 26'd5;
        begin
            int waited = 0;
            while (!req_ready_a[1] && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("mid_rst_accept", 64'(waited < 20), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_a[1] = 1'b0;
        check("mid_rst_reading", 64'(mem_read_a[1]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset(1);
        check_reset(0);
        clear_expect();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 64'(rsp_valid_a[1]), 64'd0);
        end
        do_req(1, 1'b0, 26'd5, 32'd0);
        do_req(1, 1'b1, 26'd7, 32'hCAFE_0007);
        do_req(1, 1'b0, 26'd7, 32'd0);
        do_req(0, 1'b1, 26'd3, 32'hBEEF_0003);
        do_req(0, 1'b0, 26'd3, 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
